arbitro_gato: RTL and testbench
===============================

ARBITRO_GATO -- requirements
Module: arbitro_gato

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 guarda_c1..guarda_c9  input  2 each  board cells written by the cell selector; 00 empty, 11 player 1 (X), 01 player 2 (O), 10 invalid.
REQ-005 p1_mm, p2_mm  input  1 each  move-made levels from the cell selector; a rising edge marks a committed move.
REQ-006 nuevo_juego  input  1  synchronous restart pulse.
REQ-007 turno_p1, turno_p2  output  1 each  one-hot turn grant to the cell selector; both 0 when the game is over.
REQ-008 gana_p1, gana_p2, empate  output  1 each  sticky result flags.
REQ-009 linea_ganadora  output  3  index 0-7 of the winning line, valid while gana_p1 or gana_p2 is 1.
REQ-010 jugadas  output  4  count of accepted moves, 0-9.
REQ-011 error_jugada  output  1  one-cycle pulse on a rejected move.

Function
REQ-012 SHALL implement FSM states ESPERA_P1, ESPERA_P2, EVALUA, FIN.
REQ-013 Turn outputs SHALL be: turno_p1=1 only in ESPERA_P1; turno_p2=1 only in ESPERA_P2.
REQ-014 A move event SHALL be a rising edge of the current player's mm input only; edges on the other player's input SHALL be ignored.
REQ-015 On a move event in cycle N, the FSM SHALL enter EVALUA in N+1, sample all nine cells in EVALUA, and update outputs and state in N+2.
REQ-016 The block SHALL keep a shadow board; a move SHALL be accepted only if exactly one cell differs from the shadow, that cell was 00, and its new value is the mover's code.
REQ-017 Accepted move: copy the cell into the shadow board and increment jugadas.
REQ-018 Rejected move (zero or more than one cell changed, wrong code, 10 present, or overwrite of an occupied cell): pulse error_jugada, leave shadow and jugadas unchanged, and return to the same player's ESPERA state.
REQ-019 After an accepted move, win check on the shadow board SHALL use lines in priority order: 0=c1c2c3, 1=c4c5c6, 2=c7c8c9, 3=c1c4c7, 4=c2c5c8, 5=c3c6c9, 6=c1c5c9, 7=c3c5c7. The lowest index whose three cells hold the same non-zero code wins.
REQ-020 On a win, set gana_p1 or gana_p2 and linea_ganadora, then go to FIN.
REQ-021 With no win and jugadas reaching 9, set empate and go to FIN. A win on move 9 SHALL take precedence over empate.
REQ-022 With no win and no draw, go to the other player's ESPERA state.
REQ-023 FIN SHALL hold all results and ignore mm edges until nuevo_juego or reset.
REQ-024 nuevo_juego in any state SHALL clear the shadow board, jugadas and all results and go to ESPERA_P1 next cycle; it SHALL take precedence over a simultaneous move event.
REQ-025 The mm edge detectors SHALL be re-armed on nuevo_juego by loading the current mm levels, so no spurious edge is seen.

Reset
REQ-026 While rst_n=0: state=ESPERA_P1, turno_p1=1, turno_p2=0, gana_p1=gana_p2=empate=0, linea_ganadora=0, jugadas=0, error_jugada=0, shadow board all 00, edge-detector history=0.
REQ-027 Reset asserted mid-EVALUA SHALL discard the pending move.

Configuration
REQ-028 Macro ARBITRO_GATO_SYNC_EN SHALL control input synchronisation.
- Defined: p1_mm, p2_mm and nuevo_juego pass through two-flop synchronisers before edge detection, adding 2 cycles to the REQ-015 latency.
- Undefined: inputs feed edge detection directly.

Structure
REQ-029 Package gato_pkg SHALL hold:
- cell codes VACIO=2'b00, EQUIS=2'b11, CIRCULO=2'b01;
- the FSM state enum;
- the 8-entry line-to-cell index table.
REQ-030 Combinational sub-module detector_linea SHALL take the nine shadow cells and return win flag, winner code and line index.

Verification
REQ-031 P1 plays c1, c2, c3; P2 plays c4, c5 -> gana_p1=1, linea_ganadora=0, jugadas=5, turns both 0.
REQ-032 Sequence c5 c1 c9 c3 c2 c8 c4 c6 c7 (X/O alternating) -> empate=1, jugadas=9, no gana flag.
REQ-033 P2 writes c5=01 when c5 already holds 11 -> error_jugada pulses 1 cycle, jugadas unchanged, turno_p2 remains 1.
REQ-034 p2_mm rises during ESPERA_P1 -> no state change, no error.
REQ-035 nuevo_juego in the same cycle as a p1_mm rising edge in ESPERA_P1 -> next cycle jugadas=0, ESPERA_P1, move discarded.
REQ-036 rst_n pulled low during EVALUA -> all outputs at REQ-026 values immediately; with ARBITRO_GATO_SYNC_EN defined, the accepted-move latency measures 4 cycles.

Source files
------------

// File: rtl/gato_pkg.sv
// -----------------------------------------------------------------------------
// gato_pkg
//
// Shared definitions for the tic-tac-toe referee (arbitro_gato):
//   - cell codes as written by the cell selector (VACIO, EQUIS, CIRCULO,
//     plus the INVALIDO code that must never be accepted into the board)
//   - tablero_t, the nine cells packed with index 0 = c1 ... index 8 = c9
//   - estado_t, the referee FSM states
//   - TABLA_LINEAS, the 8-entry line-to-cell index table in win priority order
//   - codigo_jugador(), mapping the mover to the code it is allowed to write
// -----------------------------------------------------------------------------
package gato_pkg;

    localparam logic [1:0] VACIO    = 2'b00;
    localparam logic [1:0] EQUIS    = 2'b11;
    localparam logic [1:0] CIRCULO  = 2'b01;
    localparam logic [1:0] INVALIDO = 2'b10;

    localparam int NUM_CELDAS = 9;
    localparam int NUM_LINEAS = 8;

    // Index 0 is c1, index 8 is c9.
    typedef logic [NUM_CELDAS-1:0][1:0] tablero_t;

    typedef enum logic [1:0] {
        ESPERA_P1 = 2'd0,
        ESPERA_P2 = 2'd1,
        EVALUA    = 2'd2,
        FIN       = 2'd3
    } estado_t;

    // Lines in priority order; each entry lists the three cell indices
    // (0-based, so c1 -> 0). Lower line index wins when several complete.
    localparam logic [3:0] TABLA_LINEAS [NUM_LINEAS][3] = '{
        '{4'd0, 4'd1, 4'd2},   // 0: c1 c2 c3
        '{4'd3, 4'd4, 4'd5},   // 1: c4 c5 c6
        '{4'd6, 4'd7, 4'd8},   // 2: c7 c8 c9
        '{4'd0, 4'd3, 4'd6},   // 3: c1 c4 c7
        '{4'd1, 4'd4, 4'd7},   // 4: c2 c5 c8
        '{4'd2, 4'd5, 4'd8},   // 5: c3 c6 c9
        '{4'd0, 4'd4, 4'd8},   // 6: c1 c5 c9
        '{4'd2, 4'd4, 4'd6}    // 7: c3 c5 c7
    };

    // Player 1 plays X, player 2 plays O.
    function automatic logic [1:0] codigo_jugador(input logic es_p2);
        return es_p2 ? CIRCULO : EQUIS;
    endfunction

endpackage

// File: rtl/detector_linea.sv
// -----------------------------------------------------------------------------
// detector_linea
//
// Purely combinational win detector. Scans the eight lines of the board and
// reports the lowest-index line whose three cells hold the same non-empty
// code.
//
// Ports:
//   celdas         in   tablero_t  nine board cells (index 0 = c1)
//   hay_ganador    out  1          a complete line exists
//   codigo_ganador out  2          code occupying the winning line
//   indice_linea   out  3          winning line index 0-7 (0 when no winner)
// -----------------------------------------------------------------------------
module detector_linea
    import gato_pkg::*;
(
    input  tablero_t   celdas,
    output logic       hay_ganador,
    output logic [1:0] codigo_ganador,
    output logic [2:0] indice_linea
);

    logic [1:0] celda_a;
    logic [1:0] celda_b;
    logic [1:0] celda_c;

    // Walk the lines from lowest to highest priority so that the last match
    // written is the lowest line index.
    always_comb begin
        hay_ganador    = 1'b0;
        codigo_ganador = VACIO;
        indice_linea   = 3'd0;
        celda_a        = VACIO;
        celda_b        = VACIO;
        celda_c        = VACIO;
        for (int l = NUM_LINEAS - 1; l >= 0; l--) begin
            celda_a = celdas[TABLA_LINEAS[3'(l)][0]];
            celda_b = celdas[TABLA_LINEAS[3'(l)][1]];
            celda_c = celdas[TABLA_LINEAS[3'(l)][2]];
            if ((celda_a != VACIO) && (celda_a == celda_b) && (celda_b == celda_c)) begin
                hay_ganador    = 1'b1;
                codigo_ganador = celda_a;
                indice_linea   = 3'(l);
            end
        end
    end

endmodule

// File: rtl/arbitro_gato.sv
// -----------------------------------------------------------------------------
// arbitro_gato
//
// Tic-tac-toe referee. Grants turns to the cell selector, validates every
// committed move against a shadow copy of the board, counts accepted moves
// and detects win/draw.
//
// Ports:
//   clk                      in   1  system clock, rising edge
//   rst_n                    in   1  asynchronous active-low reset
//   guarda_c1 .. guarda_c9   in   2  board cells as written by the selector
//   p1_mm, p2_mm             in   1  move-made levels; rising edge = commit
//   nuevo_juego              in   1  synchronous restart
//   turno_p1, turno_p2       out  1  one-hot turn grant (both 0 when busy/over)
//   gana_p1, gana_p2, empate out  1  sticky results
//   linea_ganadora           out  3  winning line index while a gana flag is 1
//   jugadas                  out  4  accepted moves, 0-9
//   error_jugada             out  1  one-cycle pulse on a rejected move
//
// Build option:
//   ARBITRO_GATO_SYNC_EN  when defined, p1_mm, p2_mm and nuevo_juego pass
//                         through two-flop synchronisers before use, adding
//                         two cycles of latency to every move and restart.
// -----------------------------------------------------------------------------
module arbitro_gato
    import gato_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] guarda_c1,
    input  logic [1:0] guarda_c2,
    input  logic [1:0] guarda_c3,
    input  logic [1:0] guarda_c4,
    input  logic [1:0] guarda_c5,
    input  logic [1:0] guarda_c6,
    input  logic [1:0] guarda_c7,
    input  logic [1:0] guarda_c8,
    input  logic [1:0] guarda_c9,
    input  logic       p1_mm,
    input  logic       p2_mm,
    input  logic       nuevo_juego,
    output logic       turno_p1,
    output logic       turno_p2,
    output logic       gana_p1,
    output logic       gana_p2,
    output logic       empate,
    output logic [2:0] linea_ganadora,
    output logic [3:0] jugadas,
    output logic       error_jugada
);

    estado_t    estado;
    estado_t    estado_sig;

    logic       p1_mm_s;
    logic       p2_mm_s;
    logic       nuevo_s;
    logic       p1_prev;
    logic       p2_prev;
    logic       evento_p1;
    logic       evento_p2;

    logic       mueve_p2;
    tablero_t   entrada;
    tablero_t   sombra;
    tablero_t   tablero_cand;

    logic [3:0] num_cambios;
    logic       cambio_ok;
    logic       hay_invalido;
    logic       jugada_valida;
    logic [1:0] codigo_mover;

    logic       hay_ganador;
    logic [1:0] codigo_ganador;
    logic [2:0] indice_linea;

    assign entrada = {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                      guarda_c4, guarda_c3, guarda_c2, guarda_c1};

`ifdef ARBITRO_GATO_SYNC_EN
    logic [1:0] sync_p1;
    logic [1:0] sync_p2;
    logic [1:0] sync_nuevo;

    // Two-flop synchronisers for the asynchronous control inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p1    <= 2'b00;
            sync_p2    <= 2'b00;
            sync_nuevo <= 2'b00;
        end else begin
            sync_p1    <= {sync_p1[0], p1_mm};
            sync_p2    <= {sync_p2[0], p2_mm};
            sync_nuevo <= {sync_nuevo[0], nuevo_juego};
        end
    end

    assign p1_mm_s = sync_p1[1];
    assign p2_mm_s = sync_p2[1];
    assign nuevo_s = sync_nuevo[1];
`else
    assign p1_mm_s = p1_mm;
    assign p2_mm_s = p2_mm;
    assign nuevo_s = nuevo_juego;
`endif

    // Edge-detector history. It follows the mm levels every cycle, which also
    // covers the restart case: on nuevo_juego the history is loaded with the
    // current levels, so a level already high is never seen as a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_prev <= 1'b0;
            p2_prev <= 1'b0;
        end else begin
            p1_prev <= p1_mm_s;
            p2_prev <= p2_mm_s;
        end
    end

    assign evento_p1 = p1_mm_s & ~p1_prev;
    assign evento_p2 = p2_mm_s & ~p2_prev;

    // Remember who committed the move under evaluation; it selects the legal
    // code and the state to return to after EVALUA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mueve_p2 <= 1'b0;
        end else if (estado == ESPERA_P1) begin
            mueve_p2 <= 1'b0;
        end else if (estado == ESPERA_P2) begin
            mueve_p2 <= 1'b1;
        end
    end

    assign codigo_mover = codigo_jugador(mueve_p2);

    // Move validation: compare the live board with the shadow board. Exactly
    // one cell may differ, it must have been empty, and it must now hold the
    // mover's code. An INVALIDO code anywhere on the live board rejects it.
    always_comb begin
        num_cambios  = 4'd0;
        cambio_ok    = 1'b1;
        hay_invalido = 1'b0;
        for (int i = 0; i < NUM_CELDAS; i++) begin
            if (entrada[4'(i)] == INVALIDO) begin
                hay_invalido = 1'b1;
            end
            if (entrada[4'(i)] != sombra[4'(i)]) begin
                num_cambios = num_cambios + 4'd1;
                if ((sombra[4'(i)] != VACIO) || (entrada[4'(i)] != codigo_mover)) begin
                    cambio_ok = 1'b0;
                end
            end
        end
        jugada_valida = (num_cambios == 4'd1) && cambio_ok && !hay_invalido;
        // With a single legal change the live board is the shadow board plus
        // the new move, so it is what the win check must look at.
        tablero_cand  = jugada_valida ? entrada : sombra;
    end

    detector_linea u_detector (
        .celdas         (tablero_cand),
        .hay_ganador    (hay_ganador),
        .codigo_ganador (codigo_ganador),
        .indice_linea   (indice_linea)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= ESPERA_P1;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic. Only the player holding the turn can trigger an
    // evaluation; a restart overrides whatever else happens this cycle.
    always_comb begin
        estado_sig = estado;
        case (estado)
            ESPERA_P1: begin
                if (evento_p1) begin
                    estado_sig = EVALUA;
                end
            end
            ESPERA_P2: begin
                if (evento_p2) begin
                    estado_sig = EVALUA;
                end
            end
            EVALUA: begin
                if (!jugada_valida) begin
                    estado_sig = mueve_p2 ? ESPERA_P2 : ESPERA_P1;
                end else if (hay_ganador) begin
                    estado_sig = FIN;
                end else if (jugadas == 4'd8) begin
                    estado_sig = FIN;
                end else begin
                    estado_sig = mueve_p2 ? ESPERA_P1 : ESPERA_P2;
                end
            end
            FIN: begin
                estado_sig = FIN;
            end
            default: begin
                estado_sig = ESPERA_P1;
            end
        endcase
        if (nuevo_s) begin
            estado_sig = ESPERA_P1;
        end
    end

    assign turno_p1 = (estado == ESPERA_P1);
    assign turno_p2 = (estado == ESPERA_P2);

    // Board, counter and result registers. They only change in EVALUA or on
    // a restart; a win on the ninth move takes precedence over the draw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sombra         <= '0;
            jugadas        <= 4'd0;
            gana_p1        <= 1'b0;
            gana_p2        <= 1'b0;
            empate         <= 1'b0;
            linea_ganadora <= 3'd0;
            error_jugada   <= 1'b0;
        end else begin
            error_jugada <= 1'b0;
            if (nuevo_s) begin
                sombra         <= '0;
                jugadas        <= 4'd0;
                gana_p1        <= 1'b0;
                gana_p2        <= 1'b0;
                empate         <= 1'b0;
                linea_ganadora <= 3'd0;
            end else if (estado == EVALUA) begin
                if (jugada_valida) begin
                    sombra  <= entrada;
                    jugadas <= jugadas + 4'd1;
                    if (hay_ganador) begin
                        gana_p1        <= (codigo_ganador == EQUIS);
                        gana_p2        <= (codigo_ganador == CIRCULO);
                        linea_ganadora <= indice_linea;
                    end else if (jugadas == 4'd8) begin
                        empate <= 1'b1;
                    end
                end else begin
                    error_jugada <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_arbitro_gato.sv
// -----------------------------------------------------------------------------
// tb_arbitro_gato
//
// Self-checking bench for arbitro_gato. A behavioural referee model (plain
// integer board, line list and move counter) predicts every output; directed
// game scenarios are followed by randomly generated games mixing legal moves,
// illegal moves and out-of-turn commits. Honours ARBITRO_GATO_SYNC_EN by
// stretching the expected move and restart latencies.
// -----------------------------------------------------------------------------
module tb_arbitro_gato;

`ifdef ARBITRO_GATO_SYNC_EN
    localparam int SYNC_CICLOS = 2;
`else
    localparam int SYNC_CICLOS = 0;
`endif
    localparam int LAT_MOVE = 2 + SYNC_CICLOS;
    localparam int LAT_NEW  = 1 + SYNC_CICLOS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] celdas [9];
    logic       p1_mm = 1'b0;
    logic       p2_mm = 1'b0;
    logic       nuevo_juego = 1'b0;

    logic       turno_p1;
    logic       turno_p2;
    logic       gana_p1;
    logic       gana_p2;
    logic       empate;
    logic [2:0] linea_ganadora;
    logic [3:0] jugadas;
    logic       error_jugada;

    int nchecks = 0;
    int npass   = 0;

    // Reference model state.
    int board [9];
    int propuesta [9];
    int m_jug;
    bit m_turn2;
    bit m_g1;
    bit m_g2;
    bit m_emp;
    int m_linea;
    bit m_over;

    int lineas [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    initial begin
        for (int i = 0; i < 9; i++) celdas[i] = 2'b00;
    end

    always #5 clk = ~clk;

    arbitro_gato dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .guarda_c1      (celdas[0]),
        .guarda_c2      (celdas[1]),
        .guarda_c3      (celdas[2]),
        .guarda_c4      (celdas[3]),
        .guarda_c5      (celdas[4]),
        .guarda_c6      (celdas[5]),
        .guarda_c7      (celdas[6]),
        .guarda_c8      (celdas[7]),
        .guarda_c9      (celdas[8]),
        .p1_mm          (p1_mm),
        .p2_mm          (p2_mm),
        .nuevo_juego    (nuevo_juego),
        .turno_p1       (turno_p1),
        .turno_p2       (turno_p2),
        .gana_p1        (gana_p1),
        .gana_p2        (gana_p2),
        .empate         (empate),
        .linea_ganadora (linea_ganadora),
        .jugadas        (jugadas),
        .error_jugada   (error_jugada)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) npass++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic checkAll(input string tag, input bit exp_err);
        checkOutput({tag, ".turno_p1"}, 32'(turno_p1), 32'(!m_over && !m_turn2));
        checkOutput({tag, ".turno_p2"}, 32'(turno_p2), 32'(!m_over && m_turn2));
        checkOutput({tag, ".gana_p1"}, 32'(gana_p1), 32'(m_g1));
        checkOutput({tag, ".gana_p2"}, 32'(gana_p2), 32'(m_g2));
        checkOutput({tag, ".empate"}, 32'(empate), 32'(m_emp));
        checkOutput({tag, ".linea"}, 32'(linea_ganadora), 32'(m_linea));
        checkOutput({tag, ".jugadas"}, 32'(jugadas), 32'(m_jug));
        checkOutput({tag, ".error"}, 32'(error_jugada), 32'(exp_err));
    endtask

    task automatic modelReset();
        for (int i = 0; i < 9; i++) board[i] = 0;
        m_jug = 0; m_turn2 = 0; m_g1 = 0; m_g2 = 0; m_emp = 0; m_linea = 0; m_over = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic driveBoard();
        for (int i = 0; i < 9; i++) celdas[i] = 2'(board[i]);
    endtask

    // A commit is legal when the selector filled exactly one empty cell with
    // the mover's symbol and nothing else on the board changed or is garbage.
    function automatic bit juzgar(input bit p2);
        int rellenas = 0;
        int otras = 0;
        int code = p2 ? 1 : 3;
        for (int i = 0; i < 9; i++) begin
            if (propuesta[i] == 2) otras++;
            else if (board[i] == 0 && propuesta[i] == code) rellenas++;
            else if (propuesta[i] != board[i]) otras++;
        end
        return (rellenas == 1) && (otras == 0);
    endfunction

    function automatic int ganador();
        for (int l = 0; l < 8; l++) begin
            if (board[lineas[l][0]] != 0 && board[lineas[l][0]] == board[lineas[l][1]]
                && board[lineas[l][1]] == board[lineas[l][2]]) return l;
        end
        return -1;
    endfunction

    // Present propuesta on the cells, raise the mover's mm, and check the
    // referee's verdict after the expected latency.
    task automatic applyStimulus(input bit p2, input string tag);
        bit exp_err = 0;
        int w;
        for (int i = 0; i < 9; i++) celdas[i] = 2'(propuesta[i]);
        if (p2) p2_mm = 1'b1; else p1_mm = 1'b1;
        ticks(LAT_MOVE - 1);
        checkOutput({tag, ".pre_jugadas"}, 32'(jugadas), 32'(m_jug));
        checkOutput({tag, ".pre_error"}, 32'(error_jugada), 32'(0));
        ticks(1);
        if (!m_over && (p2 == m_turn2)) begin
            if (juzgar(p2)) begin
                for (int i = 0; i < 9; i++) board[i] = propuesta[i];
                m_jug++;
                w = ganador();
                if (w >= 0) begin
                    if (board[lineas[w][0]] == 3) m_g1 = 1; else m_g2 = 1;
                    m_linea = w;
                    m_over = 1;
                end else if (m_jug == 9) begin
                    m_emp = 1;
                    m_over = 1;
                end else begin
                    m_turn2 = !m_turn2;
                end
            end else begin
                exp_err = 1;
            end
        end
        checkAll(tag, exp_err);
        ticks(1);
        checkOutput({tag, ".err_end"}, 32'(error_jugada), 32'(0));
        p1_mm = 1'b0;
        p2_mm = 1'b0;
        driveBoard();
        ticks(1);
    endtask

    task automatic jugar(input bit p2, input int idx, input string tag);
        for (int i = 0; i < 9; i++) propuesta[i] = board[i];
        propuesta[idx] = p2 ? 1 : 3;
        applyStimulus(p2, tag);
    endtask

    task automatic nuevoJuego(input string tag);
        for (int i = 0; i < 9; i++) celdas[i] = 2'b00;
        nuevo_juego = 1'b1;
        ticks(1);
        nuevo_juego = 1'b0;
        ticks(LAT_NEW - 1);
        modelReset();
        checkAll(tag, 0);
    endtask

    initial begin
        int seq [9] = '{4, 0, 8, 2, 1, 7, 3, 5, 6};
        int vacias [$];
        int kind;
        bit mover;
        int a;
        int b;

        modelReset();
        #1 rst_n = 1'b0;
        #2 checkAll("reset", 0);
        ticks(1);
        rst_n = 1'b1;
        ticks(1);
        checkAll("post_reset", 0);

        // P1 wins on the top row.
        nuevoJuego("ng1");
        jugar(0, 0, "w.x1");
        jugar(1, 3, "w.o4");
        jugar(0, 1, "w.x2");
        jugar(1, 4, "w.o5");
        jugar(0, 2, "w.x3");
        checkOutput("win.gana_p1", 32'(gana_p1), 32'd1);
        checkOutput("win.linea", 32'(linea_ganadora), 32'd0);
        checkOutput("win.jugadas", 32'(jugadas), 32'd5);
        checkOutput("win.turnos", 32'({turno_p1, turno_p2}), 32'd0);
        // Commits in FIN are ignored.
        jugar(1, 8, "fin.p2");
        jugar(0, 8, "fin.p1");

        // Full board, no line.
        nuevoJuego("ng2");
        for (int k = 0; k < 9; k++) jugar(k[0], seq[k], $sformatf("draw.%0d", k));
        checkOutput("draw.empate", 32'(empate), 32'd1);
        checkOutput("draw.jugadas", 32'(jugadas), 32'd9);
        checkOutput("draw.gana", 32'({gana_p1, gana_p2}), 32'd0);

        // Overwrite of an occupied cell by P2 is rejected.
        nuevoJuego("ng3");
        jugar(0, 4, "ow.x5");
        jugar(1, 4, "ow.o5");
        checkOutput("ow.turno_p2", 32'(turno_p2), 32'd1);
        checkOutput("ow.jugadas", 32'(jugadas), 32'd1);
        // Off-turn P1 commit while P2 holds the turn, then a legal P2 move.
        jugar(0, 0, "ow.offturn");
        jugar(1, 0, "ow.o1");

        // P2 edge during ESPERA_P1 is ignored.
        for (int i = 0; i < 9; i++) propuesta[i] = board[i];
        applyStimulus(1, "p2_in_p1");
        checkOutput("p2_in_p1.turno_p1", 32'(turno_p1), 32'd1);

        // Restart in the same cycle as a P1 commit: the commit is lost.
        for (int i = 0; i < 9; i++) propuesta[i] = board[i];
        propuesta[8] = 3;
        for (int i = 0; i < 9; i++) celdas[i] = 2'(propuesta[i]);
        p1_mm = 1'b1;
        nuevo_juego = 1'b1;
        ticks(1);
        nuevo_juego = 1'b0;
        ticks(LAT_NEW - 1);
        modelReset();
        checkOutput("ng_vs_mm.jugadas", 32'(jugadas), 32'd0);
        checkOutput("ng_vs_mm.turno_p1", 32'(turno_p1), 32'd1);
        ticks(LAT_MOVE + 1);
        checkAll("ng_vs_mm.later", 0);
        p1_mm = 1'b0;
        driveBoard();
        ticks(1);

        // Reset while a move is under evaluation.
        jugar(0, 4, "rst.x5");
        for (int i = 0; i < 9; i++) propuesta[i] = board[i];
        propuesta[0] = 1;
        for (int i = 0; i < 9; i++) celdas[i] = 2'(propuesta[i]);
        p2_mm = 1'b1;
        ticks(LAT_MOVE - 1);
        checkOutput("rst.evalua_turnos", 32'({turno_p1, turno_p2}), 32'd0);
        #2 rst_n = 1'b0;
        #1 modelReset();
        checkAll("rst.async", 0);
        p2_mm = 1'b0;
        driveBoard();
        ticks(2);
        rst_n = 1'b1;
        ticks(LAT_MOVE + 1);
        checkAll("rst.after", 0);

        // Random games.
        for (int g = 0; g < 8; g++) begin
            nuevoJuego($sformatf("rg%0d.ng", g));
            for (int k = 0; k < 16 && !m_over; k++) begin
                mover = ($urandom_range(0, 9) == 9) ? !m_turn2 : m_turn2;
                for (int i = 0; i < 9; i++) propuesta[i] = board[i];
                vacias.delete();
                for (int i = 0; i < 9; i++) if (board[i] == 0) vacias.push_back(i);
                kind = $urandom_range(0, 6);
                if (kind <= 2 && vacias.size() > 0) begin
                    propuesta[vacias[$urandom_range(0, vacias.size() - 1)]] = mover ? 1 : 3;
                end else if (kind == 3) begin
                    propuesta[$urandom_range(0, 8)] = $urandom_range(0, 3);
                end else if (kind == 4) begin
                    a = $urandom_range(0, 8);
                    b = $urandom_range(0, 8);
                    propuesta[a] = mover ? 1 : 3;
                    propuesta[b] = mover ? 1 : 3;
                end else if (kind == 5) begin
                    propuesta[$urandom_range(0, 8)] = 2;
                end
                applyStimulus(mover, $sformatf("rg%0d.m%0d", g, k));
            end
            if (m_over) jugar(!m_turn2, 0, $sformatf("rg%0d.fin", g));
        end

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
